// File: rtl/pipelined_array_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_array_multiplier
//  Description : Valid/ready pipelined WIDTHxWIDTH array multiplier, per-beat
//                unsigned or two's-complement operands.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_array_multiplier #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int PW   = 2 * WIDTH;
    localparam int ROWS = (WIDTH + STAGES - 1) / STAGES;

    // Rows lo..hi of the array; in signed mode the MSB row of b carries
    // negative weight, so it is subtracted rather than added.
    function automatic logic [PW-1:0] rows_sum(
        input logic [WIDTH-1:0] a_v,
        input logic [WIDTH-1:0] b_v,
        input logic             sgn,
        input int               lo,
        input int               hi
    );
        logic [PW-1:0]    a_ext;
        logic [PW-1:0]    acc;
        logic [WIDTH-1:0] bits;
        a_ext = sgn ? {{WIDTH{a_v[WIDTH-1]}}, a_v} : {{WIDTH{1'b0}}, a_v};
        acc   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bits = b_v >> i;
            if ((i >= lo) && (i <= hi) && bits[0]) begin
                if (sgn && (i == WIDTH - 1)) begin
                    acc = acc - (a_ext << i);
                end else begin
                    acc = acc + (a_ext << i);
                end
            end
        end
        return acc;
    endfunction

    logic [STAGES-1:0]            vld_q;
    logic [STAGES-1:0][WIDTH-1:0] a_q;
    logic [STAGES-1:0][WIDTH-1:0] b_q;
    logic [STAGES-1:0]            sgn_q;
    logic [STAGES-1:0][PW-1:0]    acc_q;

    logic [STAGES-1:0]            vld_d;
    logic [STAGES-1:0][WIDTH-1:0] a_d;
    logic [STAGES-1:0][WIDTH-1:0] b_d;
    logic [STAGES-1:0]            sgn_d;
    logic [STAGES-1:0][PW-1:0]    acc_d;

    logic                         out_valid_q;
    logic [PW-1:0]                product_q;
    logic                         w_advance;

    assign w_advance = !out_valid_q || out_ready;
    assign in_ready  = w_advance;
    assign out_valid = out_valid_q;
    assign product   = product_q;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            localparam int LO     = k * ROWS;
            localparam int HI_RAW = (k + 1) * ROWS - 1;
            localparam int HI     = (HI_RAW > WIDTH - 1) ? WIDTH - 1 : HI_RAW;
            if (k == 0) begin : g_head
                assign vld_d[k] = in_valid;
                assign a_d[k]   = a;
                assign b_d[k]   = b;
                assign sgn_d[k] = is_signed;
                assign acc_d[k] = rows_sum(a, b, is_signed, LO, HI);
            end else begin : g_body
                assign vld_d[k] = vld_q[k-1];
                assign a_d[k]   = a_q[k-1];
                assign b_d[k]   = b_q[k-1];
                assign sgn_d[k] = sgn_q[k-1];
                assign acc_d[k] = acc_q[k-1]
                                + rows_sum(a_q[k-1], b_q[k-1], sgn_q[k-1], LO, HI);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sgn_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            product_q   <= '0;
        end else if (w_advance) begin
            vld_q <= vld_d;
            // Bubbles leave the previously held data in place.
            for (int k = 0; k < STAGES; k++) begin
                if (vld_d[k]) begin
                    a_q[k]   <= a_d[k];
                    b_q[k]   <= b_d[k];
                    sgn_q[k] <= sgn_d[k];
                    acc_q[k] <= acc_d[k];
                end
            end
            out_valid_q <= vld_q[STAGES-1];
            if (vld_q[STAGES-1]) begin
                product_q <= acc_q[STAGES-1];
            end
        end
    end

    // The last stage's operand copies have no consumer once all rows are summed.
    logic w_unused;
    assign w_unused = ^{a_q[STAGES-1], b_q[STAGES-1], sgn_q[STAGES-1]};

endmodule
`default_nettype wire

// File: doc/pipelined_array_multiplier.md
Name: pipelined_array_multiplier

Overview:
Parametrised, pipelined successor to the combinational 16x16 array multiplier. It accumulates partial-product rows across STAGES register stages and supports unsigned or two's-complement operands, selected per transaction. A valid/ready handshake on both sides gives full throughput (one product per cycle) and allows lossless backpressure from the consumer. It sits between operand producers and the datapath accumulator.

Parameters:
WIDTH, 16, operand width in bits (2..32); product width is 2*WIDTH.
STAGES, 4, pipeline register stages (1..WIDTH); stage k sums partial-product rows [k*R, min((k+1)*R, WIDTH)-1], where R = ceil(WIDTH/STAGES).

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous reset, active-high.
in_valid  in  1  operand beat valid.
in_ready  out  1  block can accept a beat this cycle.
a  in  WIDTH  multiplicand.
b  in  WIDTH  multiplier.
is_signed  in  1  1 = a and b are two's complement; 0 = unsigned; sampled with the beat.
out_valid  out  1  product valid.
out_ready  in  1  consumer accepts the product this cycle.
product  out  2*WIDTH  result, registered.

Behaviour:
- Reset (rst=1 at a clk edge): all stage valid bits clear to 0, the product register clears to 0, and stage data registers clear to 0. Reset has priority over every other event.
- Resulting reset outputs: out_valid=0, product=0, in_ready=1.
- advance = !out_valid || out_ready. in_ready = advance, a combinational function of out_valid and out_ready only. in_ready never depends on in_valid.
- Input accept: a beat is accepted when in_valid && in_ready. On acceptance, stage 0 captures a, b, is_signed and the stage-0 partial sum.
- Shifting on advance:
  - All stage valid bits shift one stage; stage 0 valid takes in_valid.
  - A stage's data registers load only when the incoming valid is 1, so bubbles do not overwrite held data.
- Stall (advance=0): every stage register, out_valid and product hold; in_ready=0. A beat presented while stalled is not taken, and the producer must hold it.
- Latency and throughput:
  - Latency with out_ready held at 1 is exactly STAGES cycles from the accepting edge to out_valid=1 with the matching product.
  - Throughput is one beat per cycle.
  - Beats are never dropped, duplicated or reordered.
- Arithmetic:
  - Unsigned: product = a*b, exact in 2*WIDTH bits.
  - Signed: product = two's-complement a*b, exact in 2*WIDTH bits. Use sign-extended partial products or Baugh-Wooley; either is acceptable, provided all results are bit-exact.
  - is_signed travels with the beat, so mixed-mode back-to-back beats are each computed in their own mode.
- product is undefined-free: it holds the last valid result while out_valid=0, and is never X after reset.
- Mid-operation reset: every in-flight beat is discarded, and no product appears for pre-reset beats. The first beat accepted after reset emerges STAGES cycles after its accept edge.
- Simultaneous out handshake and new accept in the same cycle: allowed, and this is the full-throughput case.
- STAGES=1 degenerates to a registered multiplier with 1-cycle latency and the same handshake.

Test Plan:
1. Reset: assert rst for 2 cycles with in_valid=1 -> out_valid=0, product=0, in_ready=1, and nothing emerges afterwards.
2. Unsigned boundaries (WIDTH=16, STAGES=4, out_ready=1):
   - a=65535, b=65535 -> product=4294836225 (0xFFFE0001) exactly 4 cycles after accept.
   - a=0, b=12345 -> 0.
3. Signed boundaries, is_signed=1:
   - 0xFFFF*0xFFFF -> 0x00000001.
   - 0x8000*0x8000 -> 0x40000000.
   - 0x8000*0x7FFF -> 0xC0008000.
   - Same 0xFFFF*0xFFFF with is_signed=0 -> 0xFFFE0001.
4. Streaming: 20 random beats on consecutive cycles with mixed is_signed and out_ready=1 -> 20 products on consecutive cycles, in order, each matching its model.
5. Backpressure: stream 8 beats, drop out_ready for 3 cycles while out_valid=1 ->
   - in_ready=0 during the stall.
   - product holds its value.
   - After release, all 8 results arrive in order with no loss or duplication.
6. Mid-operation reset: accept 3 beats, assert rst at cycle 2 for one cycle, then accept 7*9 -> the only output is product=63, 4 cycles after its accept.
